// File: rtl/pipe_slice_pkg.sv
// ---------------------------------------------------------------------------
// pipe_slice_pkg
// Shared definitions for the valid/ready register-slice chain:
//   - slice mode encodings (ps_mode_t / PS_MODE_*)
//   - width of the optional statistics counters (PS_CNT_W)
//   - saturating increment helper used by those counters
// ---------------------------------------------------------------------------
package pipe_slice_pkg;

    typedef enum logic [1:0] {
        PS_MODE_PASS = 2'd0,
        PS_MODE_FWD  = 2'd1,
        PS_MODE_BWD  = 2'd2,
        PS_MODE_FULL = 2'd3
    } ps_mode_t;

    localparam int PS_CNT_W = 32;

    // Increment that sticks at all-ones instead of wrapping to zero.
    function automatic logic [PS_CNT_W-1:0] ps_sat_inc(input logic [PS_CNT_W-1:0] value);
        logic [PS_CNT_W-1:0] result;
        if (value == {PS_CNT_W{1'b1}}) begin
            result = value;
        end else begin
            result = value + {{(PS_CNT_W-1){1'b0}}, 1'b1};
        end
        return result;
    endfunction

endpackage

// File: rtl/pipe_slice.sv
// ---------------------------------------------------------------------------
// pipe_slice
// One valid/ready register slice. MODE selects the implementation:
//   0 pass-through, 1 forward-registered, 2 backward-registered (skid),
//   3 fully registered (main + skid entry).
// Ports:
//   clk, rst          clock / synchronous active-high reset
//   valid_f, data_f   upstream word offered
//   ready_f           slice accepts upstream word this cycle
//   valid_b, data_b   downstream word offered
//   ready_b           downstream accepts word this cycle
// ready_f is held low while rst is asserted in the registered modes so that
// nothing is accepted into state that is being cleared.
// ---------------------------------------------------------------------------
module pipe_slice
    import pipe_slice_pkg::*;
#(
    parameter int L    = 8,
    parameter int MODE = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         valid_f,
    input  logic [L-1:0] data_f,
    output logic         ready_f,
    output logic         valid_b,
    output logic [L-1:0] data_b,
    input  logic         ready_b
);

    if (L < 1) begin : g_bad_width
        $error("pipe_slice: L must be >= 1");
    end

    if (MODE == int'(PS_MODE_PASS)) begin : g_pass
        // Plain wires; clock and reset are intentionally not used here.
        logic pass_unused_s;
        assign pass_unused_s = clk ^ rst;
        assign ready_f       = ready_b;
        assign valid_b       = valid_f;
        assign data_b        = data_f;
    end else if (MODE == int'(PS_MODE_FWD)) begin : g_fwd
        logic         valid_q, valid_d;
        logic [L-1:0] data_q, data_d;
        logic         accept_s;

        // Space is available when empty or when the held word leaves now.
        assign ready_f  = ~rst & (~valid_q | ready_b);
        assign accept_s = valid_f & ready_f;
        assign valid_b  = valid_q;
        assign data_b   = data_q;

        // Next state: load on accept, otherwise empty once drained.
        always_comb begin
            valid_d = valid_q;
            data_d  = data_q;
            if (accept_s) begin
                valid_d = 1'b1;
                data_d  = data_f;
            end else if (ready_b) begin
                valid_d = 1'b0;
            end else begin
                valid_d = valid_q;
            end
        end

        // State register.
        always_ff @(posedge clk) begin
            if (rst) begin
                valid_q <= 1'b0;
                data_q  <= {L{1'b0}};
            end else begin
                valid_q <= valid_d;
                data_q  <= data_d;
            end
        end
    end else if (MODE == int'(PS_MODE_BWD)) begin : g_bwd
        logic         skid_valid_q, skid_valid_d;
        logic [L-1:0] skid_data_q, skid_data_d;

        // ready_f is a pure register output, cutting the combinational
        // ready path; the skid entry catches the word offered in the cycle
        // the downstream stalls.
        assign ready_f = ~rst & ~skid_valid_q;
        assign valid_b = ~rst & (valid_f | skid_valid_q);
        assign data_b  = rst ? {L{1'b0}} : (skid_valid_q ? skid_data_q : data_f);

        // Next state: skid drains on ready_b, fills on a refused accept.
        always_comb begin
            skid_valid_d = skid_valid_q;
            skid_data_d  = skid_data_q;
            if (skid_valid_q) begin
                if (ready_b) begin
                    skid_valid_d = 1'b0;
                end else begin
                    skid_valid_d = 1'b1;
                end
            end else if (valid_f & ready_f & ~ready_b) begin
                skid_valid_d = 1'b1;
                skid_data_d  = data_f;
            end else begin
                skid_valid_d = 1'b0;
            end
        end

        // State register.
        always_ff @(posedge clk) begin
            if (rst) begin
                skid_valid_q <= 1'b0;
                skid_data_q  <= {L{1'b0}};
            end else begin
                skid_valid_q <= skid_valid_d;
                skid_data_q  <= skid_data_d;
            end
        end
    end else if (MODE == int'(PS_MODE_FULL)) begin : g_full
        logic         main_valid_q, main_valid_d;
        logic [L-1:0] main_data_q, main_data_d;
        logic         skid_valid_q, skid_valid_d;
        logic [L-1:0] skid_data_q, skid_data_d;
        logic         accept_s;
        logic         drain_s;

        // Both directions registered: outputs come from the main entry and
        // ready_f only reflects skid occupancy.
        assign ready_f  = ~rst & ~skid_valid_q;
        assign valid_b  = main_valid_q;
        assign data_b   = main_data_q;
        assign accept_s = valid_f & ready_f;
        assign drain_s  = main_valid_q & ready_b;

        // Next state. A full skid implies ready_f=0, so no accept can
        // coincide with the skid-to-main move.
        always_comb begin
            main_valid_d = main_valid_q;
            main_data_d  = main_data_q;
            skid_valid_d = skid_valid_q;
            skid_data_d  = skid_data_q;
            if (skid_valid_q) begin
                if (drain_s) begin
                    main_valid_d = 1'b1;
                    main_data_d  = skid_data_q;
                    skid_valid_d = 1'b0;
                end else begin
                    skid_valid_d = 1'b1;
                end
            end else if (accept_s) begin
                if (~main_valid_q | drain_s) begin
                    main_valid_d = 1'b1;
                    main_data_d  = data_f;
                end else begin
                    skid_valid_d = 1'b1;
                    skid_data_d  = data_f;
                end
            end else if (drain_s) begin
                main_valid_d = 1'b0;
            end else begin
                main_valid_d = main_valid_q;
            end
        end

        // State register.
        always_ff @(posedge clk) begin
            if (rst) begin
                main_valid_q <= 1'b0;
                main_data_q  <= {L{1'b0}};
                skid_valid_q <= 1'b0;
                skid_data_q  <= {L{1'b0}};
            end else begin
                main_valid_q <= main_valid_d;
                main_data_q  <= main_data_d;
                skid_valid_q <= skid_valid_d;
                skid_data_q  <= skid_data_d;
            end
        end
    end else begin : g_bad_mode
        $error("pipe_slice: MODE must be 0..3");
        assign ready_f = 1'b0;
        assign valid_b = 1'b0;
        assign data_b  = {L{1'b0}};
    end

endmodule

// File: rtl/pipe_slice_chain.sv
// ---------------------------------------------------------------------------
// pipe_slice_chain
// Chain of STAGES identical valid/ready register slices (see pipe_slice)
// between a producer (_f side) and a consumer (_b side).
// Parameters: L payload width, STAGES slice count, MODE slice type (0..3).
// Ports:
//   clk, rst          clock / synchronous active-high reset
//   valid_f, data_f   producer word offered
//   ready_f           chain accepts producer word this cycle
//   valid_b, data_b   consumer word offered
//   ready_b           consumer accepts word this cycle
//   xfer_cnt          (PIPE_SLICE_CHAIN_STATS_EN) saturating count of _b transfers
//   stall_cnt         (PIPE_SLICE_CHAIN_STATS_EN) saturating count of valid_b & ~ready_b cycles
// Optional feature macro: PIPE_SLICE_CHAIN_STATS_EN.
// ---------------------------------------------------------------------------
module pipe_slice_chain
    import pipe_slice_pkg::*;
#(
    parameter int L      = 8,
    parameter int STAGES = 1,
    parameter int MODE   = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                valid_f,
    input  logic [L-1:0]        data_f,
    output logic                ready_f,
    output logic                valid_b,
    output logic [L-1:0]        data_b,
    input  logic                ready_b
`ifdef PIPE_SLICE_CHAIN_STATS_EN
    ,
    output logic [PS_CNT_W-1:0] xfer_cnt,
    output logic [PS_CNT_W-1:0] stall_cnt
`endif
);

    if (STAGES < 1) begin : g_bad_stages
        $error("pipe_slice_chain: STAGES must be >= 1");
    end
    if ((MODE < 0) || (MODE > 3)) begin : g_bad_mode
        $error("pipe_slice_chain: MODE must be 0..3");
    end

    // Each stage owns its own link signals so the ready path of a chain of
    // combinational slices is not one shared vector feeding back on itself.
    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic         f_valid_s;
        logic [L-1:0] f_data_s;
        logic         f_ready_s;
        logic         b_valid_s;
        logic [L-1:0] b_data_s;
        logic         b_ready_s;

        if (k == 0) begin : g_head
            assign f_valid_s = valid_f;
            assign f_data_s  = data_f;
        end else begin : g_link
            assign f_valid_s = g_stage[k-1].b_valid_s;
            assign f_data_s  = g_stage[k-1].b_data_s;
        end

        if (k == STAGES - 1) begin : g_tail
            assign b_ready_s = ready_b;
        end else begin : g_mid
            assign b_ready_s = g_stage[k+1].f_ready_s;
        end

        pipe_slice #(
            .L    (L),
            .MODE (MODE)
        ) u_slice (
            .clk     (clk),
            .rst     (rst),
            .valid_f (f_valid_s),
            .data_f  (f_data_s),
            .ready_f (f_ready_s),
            .valid_b (b_valid_s),
            .data_b  (b_data_s),
            .ready_b (b_ready_s)
        );
    end

    assign ready_f = g_stage[0].f_ready_s;
    assign valid_b = g_stage[STAGES-1].b_valid_s;
    assign data_b  = g_stage[STAGES-1].b_data_s;

`ifdef PIPE_SLICE_CHAIN_STATS_EN
    logic                xfer_s;
    logic                stall_s;
    logic [PS_CNT_W-1:0] xfer_cnt_q, xfer_cnt_d;
    logic [PS_CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    assign xfer_s  = valid_b & ready_b;
    assign stall_s = valid_b & ~ready_b;

    // Counter next state with saturation.
    always_comb begin
        xfer_cnt_d  = xfer_cnt_q;
        stall_cnt_d = stall_cnt_q;
        if (xfer_s) begin
            xfer_cnt_d = ps_sat_inc(xfer_cnt_q);
        end else begin
            xfer_cnt_d = xfer_cnt_q;
        end
        if (stall_s) begin
            stall_cnt_d = ps_sat_inc(stall_cnt_q);
        end else begin
            stall_cnt_d = stall_cnt_q;
        end
    end

    // Counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            xfer_cnt_q  <= {PS_CNT_W{1'b0}};
            stall_cnt_q <= {PS_CNT_W{1'b0}};
        end else begin
            xfer_cnt_q  <= xfer_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign xfer_cnt  = xfer_cnt_q;
    assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: doc/pipe_slice_chain.md
Name: pipe_slice_chain

Overview:
- Parametrised successor to the team's single-slice backward skid buffer: a chain of STAGES valid/ready register slices between a producer (the _f side) and a consumer (the _b side).
- Each slice is selectable at elaboration:
  - pass-through;
  - forward-registered (valid/data);
  - backward-registered (ready);
  - fully registered (both directions, two-entry skid).
- Used to close timing on long valid/ready paths without losing throughput.

Parameters:
- L, 8, payload width in bits (>=1)
- STAGES, 1, number of chained slices (>=1)
- MODE, 3, slice type for every stage: 0 pass-through, 1 forward, 2 backward, 3 full

Ports:
- clk  input  1  clock, all state on rising edge
- rst  input  1  reset, synchronous, active-high
- valid_f  input  1  upstream data valid
- data_f  input  L  upstream payload
- ready_f  output  1  block accepts data_f this cycle
- valid_b  output  1  downstream data valid
- data_b  output  L  downstream payload
- ready_b  input  1  downstream accepts data_b this cycle

Behaviour:
- Handshake: a transfer occurs on a side when valid and ready are both 1 at a rising clk edge.
  - valid_b never drops, and data_b never changes, while valid_b=1 and ready_b=0.
  - Data order is preserved. No word is lost or duplicated.
- Reset: while rst=1 at an edge, all slice valid flags, skid flags and data registers clear to 0.
  - Outputs during and directly after reset: valid_b=0, data_b=0.
  - ready_f=0 while rst is high in modes 1/2/3. ready_f rises the first cycle after rst falls.
  - Reset mid-transfer discards all held words.
- MODE 0: combinational wires. ready_f=ready_b, valid_b=valid_f, data_b=data_f. Latency 0. No registers.
- MODE 1 (forward): one entry per slice.
  - ready_f = ~vq | ready_b (combinational).
  - On acceptance: vq<=1, dq<=data_f.
  - On a drain with no accept: vq<=0.
  - Latency 1 cycle per stage. Full throughput.
- MODE 2 (backward): registered ready plus one skid entry per slice.
  - ready_f = ~skid_valid (register).
  - valid_b = valid_f | skid_valid.
  - data_b = skid_valid ? skid_data : data_f.
  - Skid loads when valid_f & ready_f & ~ready_b. Skid empties when ready_b=1.
  - Latency 0. Full throughput.
- MODE 3 (full): main entry plus skid entry per slice. valid_b and data_b come from the main register; ready_f = ~skid_valid (register).
  - Accept while main empty, or main draining this cycle: load main.
  - Accept while main full and not draining: load skid; ready_f falls next cycle.
  - Main draining while skid full: skid moves to main, skid clears.
  - Simultaneous accept and drain with skid empty: main replaced, no bubble.
  - Latency 1 cycle per stage. Sustains 1 word/cycle. Holds 2 words per stage.
- Chain: stage k _b side feeds stage k+1 _f side.
  - Total latency: 0 (modes 0/2), STAGES cycles (modes 1/3).
  - Capacity: 0 / STAGES / STAGES / 2*STAGES words for modes 0/1/2/3.
- Illegal MODE (>3) or STAGES<1: elaboration error.

Optional Feature:
- Macro PIPE_SLICE_CHAIN_STATS_EN.
- Defined: adds outputs xfer_cnt (32, count of _b-side transfers) and stall_cnt (32, cycles with valid_b=1 & ready_b=0).
  - Both counters saturate at 32'hFFFFFFFF and clear on rst.
- Undefined: the ports and counters do not exist. Behaviour is otherwise identical.

Decomposition:
- Package pipe_slice_pkg holds:
  - mode constants PS_MODE_PASS=0, PS_MODE_FWD=1, PS_MODE_BWD=2, PS_MODE_FULL=3;
  - typedef ps_mode_t (2-bit);
  - STATS counter width constant PS_CNT_W=32.
- One sub-module, pipe_slice, implements a single stage for any MODE. The top generates STAGES instances and the optional counters.

Test Plan:
- Reset (L=8, STAGES=2, MODE=3): rst high 3 cycles with valid_f=1, data_f=8'hAA -> valid_b=0, ready_f=0 throughout. One cycle after release, ready_f=1. No word output until a post-reset accept.
- Streaming (MODE=3, STAGES=2): send 0x01..0x10 back-to-back, ready_b=1 -> 0x01 on valid_b exactly 2 cycles after its accept, then one word per cycle, in order, no bubbles.
- Backpressure (MODE=3, STAGES=1): ready_b=0 while pushing 0x11,0x22,0x33 -> 0x11 and 0x22 accepted, ready_f=0 from the cycle after 0x22. On ready_b=1, output is 0x11,0x22,0x33 in order and data_b is stable while stalled.
- Backward mode (MODE=2, STAGES=1): push 0x5A with ready_b=0 -> valid_b=1 and data_b=0x5A in the same cycle, ready_f=0 next cycle. On ready_b=1, the skid drains and ready_f=1 the cycle after.
- Random ready_b (all MODEs, STAGES=3, L=16): 1000 words with random valid_f/ready_b -> scoreboard order matches, no loss or duplicate, occupancy never exceeds capacity.
- Stats (PIPE_SLICE_CHAIN_STATS_EN defined, MODE=1): 10 transfers plus 4 stalled cycles -> xfer_cnt=10, stall_cnt=4. Both read 0 after rst.
